// File: rtl/sma_pulse_sequencer_pkg.sv
// Shared constants for the SMA pulse sequencer: register map, CTRL/STATUS bit
// positions and the sequencer state encoding.
package sma_pulse_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] REG_CTRL   = 3'd0;
    localparam logic [ADDR_W-1:0] REG_PERIOD = 3'd1;
    localparam logic [ADDR_W-1:0] REG_HIGH   = 3'd2;
    localparam logic [ADDR_W-1:0] REG_COUNT  = 3'd3;
    localparam logic [ADDR_W-1:0] REG_STATUS = 3'd4;
    localparam logic [ADDR_W-1:0] REG_REMAIN = 3'd5;

    localparam int CTRL_START  = 0;
    localparam int CTRL_STOP   = 1;
    localparam int CTRL_LEVEL  = 2;
    localparam int CTRL_MODE   = 3;
    localparam int CTRL_IRQ_EN = 4;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

endpackage

// File: rtl/sma_pulse_sequencer_if.sv
// Avalon-MM slave port of the SMA pulse sequencer (zero wait states, no read strobe).
interface sma_pulse_sequencer_if;
    import sma_pulse_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/sma_pulse_sequencer_timer.sv
// Pulse timer: shadow period/high/count latched at start, phase and remaining-pulse
// counters, and the per-cycle pulse compare and last-cycle flag.
module sma_pulse_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             run_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] high_i,
    input  logic [CNT_W-1:0] count_i,
    output logic             pulse_hi_o,
    output logic             last_o,
    output logic [CNT_W-1:0] remain_o
);

    logic [CNT_W-1:0] p_q, p_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] ph_q, ph_d;
    logic [CNT_W-1:0] p_eff;
    logic             wrap;

    // A period below 2 cannot hold both a high and a low phase counter value.
    assign p_eff = (period_i < CNT_W'(2)) ? CNT_W'(2) : period_i;
    assign wrap  = (ph_q == p_q - CNT_W'(1));

    always_comb begin
        // NOTE: every *_d gets its hold value first so no path leaves one unassigned (no latch).
        p_d   = p_q;
        h_d   = h_q;
        n_d   = n_q;
        rem_d = rem_q;
        ph_d  = ph_q;
        if (load_i) begin
            p_d   = p_eff;
            h_d   = (high_i > p_eff) ? p_eff : high_i;
            n_d   = count_i;
            rem_d = count_i;
            ph_d  = '0;
        end else if (run_i) begin
            if (wrap) begin
                ph_d = '0;
                if (n_q != '0) rem_d = rem_q - CNT_W'(1);
            end else begin
                ph_d = ph_q + CNT_W'(1);
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments; reset is asynchronous, active-low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_q   <= '0;
            h_q   <= '0;
            n_q   <= '0;
            rem_q <= '0;
            ph_q  <= '0;
        end else begin
            p_q   <= p_d;
            h_q   <= h_d;
            n_q   <= n_d;
            rem_q <= rem_d;
            ph_q  <= ph_d;
        end
    end

    assign pulse_hi_o = (ph_q < h_q);
    assign last_o     = run_i && wrap && (n_q != '0) && (rem_q == CNT_W'(1));
    assign remain_o   = rem_q;

endmodule

// File: rtl/sma_pulse_sequencer.sv
// SMA output driver: Avalon register file, IDLE/RUN sequencer FSM, sticky done/irq
// and the registered pin mux (manual level or timed pulse train).
module sma_pulse_sequencer
    import sma_pulse_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic                    clk,
    input  logic                    reset_n,
    sma_pulse_sequencer_if.slave    bus,
    output logic                    sma_out,
    output logic                    irq,
    output logic                    busy
);

    logic [DATA_W-1:0] wd;
    logic              wr_en, ctrl_wr, status_wr;
    logic              start_go, abort;
    logic              wd_unused;

    logic              level_q, mode_q, irq_en_q;
    logic [CNT_W-1:0]  period_q, high_q, count_q;

    seq_state_e        state_q, state_d;
    logic              finish_q, finish_d;
    logic              done_q, done_d;
    logic              sma_q, sma_d;
    logic              busy_q, busy_d;

    logic              pulse_hi, last;
    logic [CNT_W-1:0]  remain;

    assign wd        = bus.writedata;
    assign wd_unused = ^(wd >> CNT_W);
    assign wr_en     = bus.chipselect && !bus.write_n;
    assign ctrl_wr   = wr_en && (bus.address == REG_CTRL);
    assign status_wr = wr_en && (bus.address == REG_STATUS);

    // STOP beats START, and clearing MODE in the same write also aborts a run.
    assign start_go = ctrl_wr && wd[CTRL_START] && wd[CTRL_MODE] && !wd[CTRL_STOP];
    assign abort    = ctrl_wr && (wd[CTRL_STOP] || !wd[CTRL_MODE]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q  <= 1'b0;
            mode_q   <= 1'b0;
            irq_en_q <= 1'b0;
            period_q <= '0;
            high_q   <= '0;
            count_q  <= '0;
        end else if (wr_en) begin
            case (bus.address)
                REG_CTRL: begin
                    level_q  <= wd[CTRL_LEVEL];
                    mode_q   <= wd[CTRL_MODE];
                    irq_en_q <= wd[CTRL_IRQ_EN];
                end
                REG_PERIOD: period_q <= wd[CNT_W-1:0];
                REG_HIGH:   high_q   <= wd[CNT_W-1:0];
                REG_COUNT:  count_q  <= wd[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    sma_pulse_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (start_go),
        .run_i      (state_q == RUN),
        .period_i   (period_q),
        .high_i     (high_q),
        .count_i    (count_q),
        .pulse_hi_o (pulse_hi),
        .last_o     (last),
        .remain_o   (remain)
    );

    always_comb begin
        state_d  = state_q;
        finish_d = 1'b0;
        case (state_q)
            IDLE: if (start_go) state_d = RUN;
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!start_go && last) begin
                    state_d  = IDLE;
                    finish_d = 1'b1;
                end
            end
        endcase
    end

    // finish_q delays done by one cycle so it lines up with the pin and busy dropping.
    always_comb begin
        sma_d  = mode_q ? ((state_q == RUN) && pulse_hi) : level_q;
        busy_d = (state_q == RUN);
        done_d = done_q;
        if (status_wr && wd[STAT_DONE]) done_d = 1'b0;
        if (finish_q)                   done_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            finish_q <= 1'b0;
            done_q   <= 1'b0;
            sma_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            finish_q <= finish_d;
            done_q   <= done_d;
            sma_q    <= sma_d;
            busy_q   <= busy_d;
        end
    end

    assign sma_out = sma_q;
    assign busy    = busy_q;
    assign irq     = done_q && irq_en_q;

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            REG_CTRL: begin
                bus.readdata[CTRL_LEVEL]  = level_q;
                bus.readdata[CTRL_MODE]   = mode_q;
                bus.readdata[CTRL_IRQ_EN] = irq_en_q;
            end
            REG_PERIOD: bus.readdata[CNT_W-1:0] = period_q;
            REG_HIGH:   bus.readdata[CNT_W-1:0] = high_q;
            REG_COUNT:  bus.readdata[CNT_W-1:0] = count_q;
            REG_STATUS: begin
                bus.readdata[STAT_BUSY] = busy_q;
                bus.readdata[STAT_DONE] = done_q;
            end
            REG_REMAIN: bus.readdata[CNT_W-1:0] = remain;
            default: ;
        endcase
    end

endmodule
